// File: rtl/knob_input.sv
// Rotary-encoder / push-button front end packed into one polled 32-bit status word.
// Latency: pin -> debounced level 2 + DEB_DIV*(DEB_LEN-1) + 1 .. 2 + DEB_DIV*DEB_LEN cycles, then 2 cycles to status; clr shows 1 cycle after its edge.
// Backpressure: none; software polls status, there is no handshake or acknowledge.
//
// Ports:
//   clk24          system clock
//   reset          synchronous, active-high
//   enc_a, enc_b   [NENC] encoder quadrature pins, asynchronous, idle high
//   btn_n          [NBTN] button pins, asynchronous, active-low
//   clr            one-cycle pulse: zero all counts, quarter accumulators and error bits
//   status         [31:0] registered word: counts [8i+7:8i], errors [16+i] (NENC<3),
//                  button levels [27:24] (pressed=1), press toggles [31:28]
//
// Build option: define KNOB_X4_EN for x4 mode (every legal quarter step moves the count
// by one; the detent accumulator is not built). Default is one count per detent.
module knob_input #(
  parameter int NENC    = 2,
  parameter int NBTN    = 4,
  parameter int DEB_DIV = 240,
  parameter int DEB_LEN = 4
) (
  input  logic            clk24,
  input  logic            reset,
  input  logic [NENC-1:0] enc_a,
  input  logic [NENC-1:0] enc_b,
  input  logic [NBTN-1:0] btn_n,
  input  logic            clr,
  output logic [31:0]     status
);

  // Signal order in every per-pin vector: {btn_n, enc_b, enc_a}
  localparam int NSIG = 2*NENC + NBTN;
  localparam int PW   = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

  logic [NSIG-1:0] pins;
  logic [NSIG-1:0] sync1;
  logic [NSIG-1:0] sync2;
  logic [NSIG-1:0] deb;

  assign pins = {btn_n, enc_b, enc_a};

  // 2-FF synchroniser, idle-high reset so nothing looks like an edge after reset
  always_ff @(posedge clk24) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
    end
  end

  // Sample-tick prescaler
  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PW'(DEB_DIV-1));

  always_ff @(posedge clk24) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Per-signal debouncer. The acceptance test looks at the history including the
  // sample being shifted in, so the level moves on the DEB_LEN-th agreeing tick.
  for (genvar s = 0; s < NSIG; s++) begin : g_deb
    logic [DEB_LEN-1:0] hist;
    logic [DEB_LEN-1:0] hist_nxt;
    logic               lvl;

    assign hist_nxt = {hist[DEB_LEN-2:0], sync2[s]};
    assign deb[s]   = lvl;

    always_ff @(posedge clk24) begin
      if (reset) begin
        hist <= '1;
        lvl  <= 1'b1;
      end else if (tick) begin
        hist <= hist_nxt;
        if (&hist_nxt) begin
          lvl <= 1'b1;
        end else if (~|hist_nxt) begin
          lvl <= 1'b0;
        end
      end
    end
  end

  // Quadrature decode and detent counting, one instance per encoder
  logic [7:0]      cnt_w [NENC];
  logic [NENC-1:0] err_w;

  for (genvar e = 0; e < NENC; e++) begin : g_enc
    logic [1:0] cur;
    logic [1:0] prev;
    logic [7:0] count;
    logic       err_r;
    logic       chg;
    logic       dbl;
    logic       fwd;
    logic       rev;

    assign cur      = {deb[e], deb[NENC+e]};
    assign cnt_w[e] = count;
    assign err_w[e] = err_r;

    // Forward successor of {a,b} is {b,~a}: 11->10->00->01->11.
    // Any other single-bit change is a reverse step.
    always_comb begin
      chg = (cur != prev);
      dbl = ((cur ^ prev) == 2'b11);
      fwd = chg && !dbl && (cur == {prev[0], ~prev[1]});
      rev = chg && !dbl && !fwd;
    end

`ifdef KNOB_X4_EN
    always_ff @(posedge clk24) begin
      if (reset) begin
        prev  <= 2'b11;
        count <= '0;
        err_r <= 1'b0;
      end else begin
        prev <= cur;
        if (clr) begin
          count <= '0;
          err_r <= 1'b0;
        end else begin
          if (dbl) begin
            err_r <= 1'b1;
          end
          if (fwd) begin
            count <= count + 8'd1;
          end else if (rev) begin
            count <= count - 8'd1;
          end
        end
      end
    end
`else
    // q carries one bit beyond the 3-bit quarter range so that +4 is representable
    logic signed [3:0] q;
    logic signed [3:0] q_step;
    logic              ent;

    assign ent = chg && (cur == 2'b11);

    always_comb begin
      q_step = q;
      if (fwd) begin
        q_step = (q == 4'sd4) ? q : q + 4'sd1;
      end else if (rev) begin
        q_step = (q == -4'sd4) ? q : q - 4'sd1;
      end
    end

    always_ff @(posedge clk24) begin
      if (reset) begin
        prev  <= 2'b11;
        count <= '0;
        q     <= '0;
        err_r <= 1'b0;
      end else begin
        prev <= cur;
        if (clr) begin
          count <= '0;
          q     <= '0;
          err_r <= 1'b0;
        end else begin
          if (dbl) begin
            err_r <= 1'b1;
          end
          if (ent) begin
            // Every arrival at the detent restarts the quarter accumulator;
            // an illegal jump into the detent never counts.
            q <= '0;
            if (!dbl && (q_step >= 4'sd3)) begin
              count <= count + 8'd1;
            end else if (!dbl && (q_step <= -4'sd3)) begin
              count <= count - 8'd1;
            end
          end else begin
            q <= q_step;
          end
        end
      end
    end
`endif
  end

  // Buttons: registered alongside the counters so all status fields share one pipeline depth
  logic [NBTN-1:0] pressed;
  logic [NBTN-1:0] btn_lvl;
  logic [NBTN-1:0] btn_tog;

  assign pressed = ~deb[2*NENC +: NBTN];

  always_ff @(posedge clk24) begin
    if (reset) begin
      btn_lvl <= '0;
      btn_tog <= '0;
    end else begin
      btn_lvl <= pressed;
      btn_tog <= btn_tog ^ (pressed & ~btn_lvl);
    end
  end

  // Status packing
  logic [31:0] st_nxt;

  always_comb begin
    st_nxt = '0;
    for (int i = 0; i < NENC; i++) begin
      st_nxt[8*i +: 8] = cnt_w[i];
    end
    if (NENC < 3) begin
      for (int i = 0; i < NENC; i++) begin
        st_nxt[16+i] = err_w[i];
      end
    end
    st_nxt[24 +: NBTN] = btn_lvl;
    st_nxt[28 +: NBTN] = btn_tog;
  end

  always_ff @(posedge clk24) begin
    if (reset) begin
      status <= '0;
    end else begin
      status <= st_nxt;
    end
  end

endmodule

// File: tb/tb_knob_input.sv
// Directed bench for knob_input with DEB_DIV=4, DEB_LEN=4, NENC=2, NBTN=4.
// Table rows hold pin levels for a fixed number of cycles, then compare the whole status word.
// Hand-written sequences cover glitches, counter wrap, the clr/step collision and mid-run reset.
module tb_knob_input;

  logic        clk24;
  logic        reset;
  logic [1:0]  enc_a;
  logic [1:0]  enc_b;
  logic [3:0]  btn_n;
  logic        clr;
  logic [31:0] status;

  int n_tot;
  int n_bad;
  int cyc;

  knob_input #(
    .NENC    (2),
    .NBTN    (4),
    .DEB_DIV (4),
    .DEB_LEN (4)
  ) dut (
    .clk24  (clk24),
    .reset  (reset),
    .enc_a  (enc_a),
    .enc_b  (enc_b),
    .btn_n  (btn_n),
    .clr    (clr),
    .status (status)
  );

  initial clk24 = 1'b0;
  always #5 clk24 = ~clk24;

  typedef struct {
    string       name;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [3:0]  bn;
    logic        clr;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after each edge
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk24);
      #1;
      cyc++;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] exp);
    n_tot++;
    if (status !== exp) begin
      n_bad++;
      $display("FAIL %s: status=%08h expected=%08h", nm, status, exp);
    end
  endtask

  // One forward detent on encoder 0 starting from 11, each state held h cycles
  task automatic detent0(input int h);
    enc_a[0] = 1'b1; enc_b[0] = 1'b0; tick_n(h);
    enc_a[0] = 1'b0;                  tick_n(h);
    enc_b[0] = 1'b1;                  tick_n(h);
    enc_a[0] = 1'b1;                  tick_n(h);
  endtask

  initial begin
    int lat;

    n_tot = 0;
    n_bad = 0;
    cyc   = 0;
    enc_a = 2'b11;
    enc_b = 2'b11;
    btn_n = 4'hF;
    clr   = 1'b0;
    reset = 1'b1;

    //             name       a      b      bn     clr   hold exp
    tbl.push_back('{"fwd_10",  2'b11, 2'b10, 4'hF, 1'b0, 40, 32'h0000_0000});
    tbl.push_back('{"fwd_00",  2'b10, 2'b10, 4'hF, 1'b0, 40, 32'h0000_0000});
    tbl.push_back('{"fwd_01",  2'b10, 2'b11, 4'hF, 1'b0, 40, 32'h0000_0000});
    tbl.push_back('{"fwd_11",  2'b11, 2'b11, 4'hF, 1'b0, 40, 32'h0000_0001});
    tbl.push_back('{"rev_01",  2'b01, 2'b11, 4'hF, 1'b0, 40, 32'h0000_0001});
    tbl.push_back('{"rev_00",  2'b01, 2'b01, 4'hF, 1'b0, 40, 32'h0000_0001});
    tbl.push_back('{"rev_10",  2'b11, 2'b01, 4'hF, 1'b0, 40, 32'h0000_0001});
    tbl.push_back('{"rev_11",  2'b11, 2'b11, 4'hF, 1'b0, 40, 32'h0000_FF01});
    tbl.push_back('{"clr",     2'b11, 2'b11, 4'hF, 1'b1,  2, 32'h0000_0000});
    tbl.push_back('{"half_10", 2'b11, 2'b10, 4'hF, 1'b0, 40, 32'h0000_0000});
    tbl.push_back('{"half_11", 2'b11, 2'b11, 4'hF, 1'b0, 40, 32'h0000_0000});
    tbl.push_back('{"post_10", 2'b11, 2'b10, 4'hF, 1'b0, 40, 32'h0000_0000});
    tbl.push_back('{"post_00", 2'b10, 2'b10, 4'hF, 1'b0, 40, 32'h0000_0000});
    tbl.push_back('{"post_01", 2'b10, 2'b11, 4'hF, 1'b0, 40, 32'h0000_0000});
    tbl.push_back('{"post_11", 2'b11, 2'b11, 4'hF, 1'b0, 40, 32'h0000_0001});
    tbl.push_back('{"ill_00",  2'b10, 2'b10, 4'hF, 1'b0, 40, 32'h0001_0001});
    tbl.push_back('{"ill_11",  2'b11, 2'b11, 4'hF, 1'b0, 40, 32'h0001_0001});
    tbl.push_back('{"ill_clr", 2'b11, 2'b11, 4'hF, 1'b1,  2, 32'h0000_0000});
    tbl.push_back('{"btn_p1",  2'b11, 2'b11, 4'hB, 1'b0, 40, 32'h4400_0000});
    tbl.push_back('{"btn_r1",  2'b11, 2'b11, 4'hF, 1'b0, 40, 32'h4000_0000});
    tbl.push_back('{"btn_p2",  2'b11, 2'b11, 4'hB, 1'b0, 40, 32'h0400_0000});
    tbl.push_back('{"btn_r2",  2'b11, 2'b11, 4'hF, 1'b0, 40, 32'h0000_0000});

    // Reset and idle
    tick_n(5);
    reset = 1'b0;
    cyc   = 0;
    check("reset", 32'h0);
    tick_n(200);
    check("idle", 32'h0);

    // Table-driven vectors
    foreach (tbl[i]) begin
      enc_a = tbl[i].a;
      enc_b = tbl[i].b;
      btn_n = tbl[i].bn;
      if (tbl[i].clr) begin
        clr = 1'b1;
        tick_n(1);
        clr = 1'b0;
        tick_n(tbl[i].hold - 1);
      end else begin
        tick_n(tbl[i].hold);
      end
      check(tbl[i].name, tbl[i].exp);
    end

    // Glitches shorter than the debounce window: an encoder-0 double-bit glitch
    // (would flag an error) plus a button glitch (would toggle bit 28)
    enc_a[0] = 1'b0;
    enc_b[0] = 1'b0;
    btn_n[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 8) begin
        enc_a[0] = 1'b1;
        enc_b[0] = 1'b1;
        btn_n[0] = 1'b1;
      end
      tick_n(1);
      check("glitch", 32'h0);
    end

    // Counter wrap on encoder 0 starting from zero
    clr = 1'b1;
    tick_n(1);
    clr = 1'b0;
    tick_n(1);
    check("wrap_clr", 32'h0);
    for (int i = 0; i < 255; i++) begin
      detent0(24);
    end
    check("wrap_ff", 32'h0000_00FF);
    detent0(24);
    check("wrap_00", 32'h0000_0000);
    detent0(24);
    check("wrap_01", 32'h0000_0001);

    // Measure step latency from the final pin change to status at a fixed prescaler phase
    enc_a[0] = 1'b1; enc_b[0] = 1'b0; tick_n(40);
    enc_a[0] = 1'b0;                  tick_n(40);
    enc_b[0] = 1'b1;                  tick_n(40);
    while ((cyc % 4) != 0) tick_n(1);
    enc_a[0] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick_n(1);
      if (lat == 0 && status[7:0] != 8'h01) lat = i;
    end
    n_tot++;
    if (lat < 17 || lat > 20) begin
      n_bad++;
      $display("FAIL latency: measured=%0d expected 17..20", lat);
      lat = 20;
    end
    check("lat_cnt", 32'h0000_0002);

    // clr on the very edge where the detent step lands: clear must win
    enc_a[0] = 1'b1; enc_b[0] = 1'b0; tick_n(40);
    enc_a[0] = 1'b0;                  tick_n(40);
    enc_b[0] = 1'b1;                  tick_n(40);
    while ((cyc % 4) != 0) tick_n(1);
    enc_a[0] = 1'b1;
    tick_n(lat - 2);
    clr = 1'b1;
    tick_n(1);
    clr = 1'b0;
    tick_n(40);
    check("collide", 32'h0);

    // Reset in mid-operation drops the button toggle state
    btn_n = 4'hB;
    tick_n(40);
    check("mr_press", 32'h4400_0000);
    btn_n = 4'hF;
    tick_n(40);
    check("mr_release", 32'h4000_0000);
    reset = 1'b1;
    tick_n(1);
    check("mr_reset", 32'h0);
    reset = 1'b0;
    cyc   = 0;
    tick_n(40);
    check("mr_after", 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
